axil_weight_loader: RTL and testbench

//  AXI4-Lite initiator that programs and reads back 16-bit synaptic weights held in the

---
 rtl/axil_weight_loader_pkg.sv | 27 ++
 rtl/axil_weight_loader_if.sv | 43 ++++
 rtl/axil_weight_loader_watchdog.sv | 36 +++
 rtl/axil_weight_loader.sv | 259 +++++++++++++++++++++++++
 tb/tb_axil_weight_loader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_weight_loader_pkg.sv
// rtl/axil_weight_loader_pkg.sv - shared types and constants for the AXI4-Lite weight loader
//
// Package spk_axil_pkg
//   AXI_RESP_*      AXI4-Lite response codes
//   loader_state_t  loader FSM states
//   WEIGHT_W        synaptic weight width in bits
//   WSTRB_WEIGHT    byte strobe covering the low 16 bits of a 32-bit beat
package spk_axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int         WEIGHT_W     = 16;
  localparam logic [3:0] WSTRB_WEIGHT = 4'b0011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    WR_B = 3'd2,
    RD_A = 3'd3,
    RD_D = 3'd4,
    RSP  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/axil_weight_loader_if.sv
// rtl/axil_weight_loader_if.sv - AXI4-Lite bus bundle between the loader and the weight memory
//
// Signals: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//          B (bresp/bvalid/bready), AR (araddr/arvalid/arready),
//          R (rdata/rresp/rvalid/rready).
// Modports: master (loader side), slave (responder side).
interface axil_weight_loader_if;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_weight_loader_watchdog.sv
// rtl/axil_weight_loader_watchdog.sv - per-phase cycle watchdog used by the weight loader
//
// Module axil_phase_watchdog (only instantiated when AXIL_LOADER_TIMEOUT_EN is defined)
//   clk, rst   clock, asynchronous active-high reset
//   load       restart the count (phase changed)
//   tick       phase is being timed this cycle
//   expire     this is the TIMEOUT_CYCLES-th timed cycle of the current phase
module axil_phase_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt_q;

  // Expiry always forces a phase change in the loader, so the count never
  // needs to saturate: the following load restarts it.
  assign expire = tick && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/axil_weight_loader.sv
// rtl/axil_weight_loader.sv - AXI4-Lite initiator that writes/reads 16-bit synaptic weights
//
// One command at a time is turned into a single AXI4-Lite transaction; the
// outcome is returned on a held response port. Optional per-phase watchdog
// enabled by the macro AXIL_LOADER_TIMEOUT_EN.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_write/index/wdata     1 = write weight, synapse index, weight to write
//   rsp_valid/rsp_ready       response handshake (held until consumed)
//   rsp_rdata/rsp_err         read weight (0 on write/error), error flag
//   busy                      loader not idle
//   err_count                 saturating count of error responses
//   timeout_flag              sticky watchdog expiry flag (0 without the macro)
//   m_axi                     AXI4-Lite master port
module axil_weight_loader
  import spk_axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          NUM_SYNAPSES   = 72401,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [31:0]         cmd_index,
  input  logic [WEIGHT_W-1:0] cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WEIGHT_W-1:0] rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [15:0]         err_count,
  output logic                timeout_flag,
  axil_weight_loader_if.master m_axi
);

  localparam logic [31:0] IDX_LIMIT = NUM_SYNAPSES;

  loader_state_t       state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WEIGHT_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic [15:0]         err_count_q, err_count_d;
  logic [31:0]         addr_q, addr_d;
  logic [WEIGHT_W-1:0] wdata_q, wdata_d;

  // Only the low weight bits of a read beat carry information.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^m_axi.rdata[31:16];

`ifdef AXIL_LOADER_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic wd_load, wd_tick, wd_expire;

  assign wd_tick = (state_q == WR) || (state_q == WR_B) ||
                   (state_q == RD_A) || (state_q == RD_D);
  assign wd_load = (state_d != state_q);

  axil_phase_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .load  (wd_load),
    .tick  (wd_tick),
    .expire(wd_expire)
  );

  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef AXIL_LOADER_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = BASE_ADDR + {cmd_index[29:0], 2'b00};
          wdata_d     = cmd_wdata;
          if (cmd_index >= IDX_LIMIT) begin
            // Out-of-range index: answer locally, never touch the bus.
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (cmd_write) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_A;
            arvalid_d = 1'b1;
          end
        end
      end

      WR: begin
        // AW and W complete independently; each valid holds until its own handshake.
        if (awvalid_q && m_axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end

      WR_B: begin
        if (m_axi.bvalid) begin
          bready_d    = 1'b0;
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_axi.bresp != AXI_RESP_OKAY);
          rsp_rdata_d = '0;
        end
      end

      RD_A: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_D;
        end
      end

      RD_D: begin
        if (m_axi.rvalid) begin
          rready_d    = 1'b0;
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (m_axi.rresp != AXI_RESP_OKAY);
          rsp_rdata_d = (m_axi.rresp != AXI_RESP_OKAY) ? '0 : m_axi.rdata[WEIGHT_W-1:0];
        end
      end

      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase

`ifdef AXIL_LOADER_TIMEOUT_EN
    // A stuck responder: abandon the transaction and report an error.
    if (wd_expire) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      timeout_d   = 1'b1;
      state_d     = RSP;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end
`endif

    // Count once per error response, at the edge where rsp_valid rises.
    if (rsp_valid_d && !rsp_valid_q && rsp_err_d && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_count_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      err_count_q <= err_count_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

`ifdef AXIL_LOADER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_d;
  end
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign busy          = busy_q;
  assign err_count     = err_count_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = {16'h0000, wdata_q};
  assign m_axi.wstrb   = WSTRB_WEIGHT;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axil_weight_loader.sv
// tb/tb_axil_weight_loader.sv - self-checking bench for axil_weight_loader
module tb_axil_weight_loader;

  localparam int NUM = 72401;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_index;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy, timeout_flag;
  logic [15:0] rsp_rdata, err_count;

  axil_weight_loader_if bus ();

  axil_weight_loader #(
    .BASE_ADDR     (32'h0000_0000),
    .NUM_SYNAPSES  (NUM),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_index   (cmd_index),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .err_count   (err_count),
    .timeout_flag(timeout_flag),
    .m_axi       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- responder (weight memory stand-in) ----------------
  int  aw_lat, w_lat;
  bit  b_err, r_err, b_never;
  int  aw_cnt, w_cnt;
  int  aw_hs_n, w_hs_n, ar_hs_n;
  int  aw_hs_cyc, w_hs_cyc;
  int  stab_err;
  bit  aw_done, w_done, aw_pend, w_pend;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr, prev_awaddr, prev_wdata;
  logic [3:0]  cap_wstrb, prev_wstrb;
  logic [15:0] resp_mem [logic [31:0]];
  logic [31:0] wr_a, wr_d, rd_key, rnd;
  logic [15:0] rd_val;
  bit          aw_fire, w_fire;

  assign bus.awready = (aw_cnt == aw_lat);
  assign bus.wready  = (w_cnt == w_lat);
  assign bus.arready = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; aw_done <= 0; w_done <= 0;
      aw_pend <= 0; w_pend <= 0;
      bus.bvalid <= 0; bus.bresp <= 0; bus.rvalid <= 0; bus.rresp <= 0; bus.rdata <= 0;
    end else begin
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      // A pending valid must stay high with an unchanged payload.
      if (aw_pend && (!bus.awvalid || bus.awaddr !== prev_awaddr)) stab_err <= stab_err + 1;
      if (w_pend && (!bus.wvalid || bus.wdata !== prev_wdata || bus.wstrb !== prev_wstrb))
        stab_err <= stab_err + 1;
      aw_pend <= bus.awvalid && !bus.awready;
      w_pend  <= bus.wvalid && !bus.wready;
      prev_awaddr <= bus.awaddr;
      prev_wdata  <= bus.wdata;
      prev_wstrb  <= bus.wstrb;
      if (bus.awvalid) begin
        if (aw_fire) begin
          aw_cnt <= 0; aw_done <= 1; cap_awaddr <= bus.awaddr;
          aw_hs_cyc <= cyc; aw_hs_n <= aw_hs_n + 1;
        end else aw_cnt <= aw_cnt + 1;
      end
      if (bus.wvalid) begin
        if (w_fire) begin
          w_cnt <= 0; w_done <= 1; cap_wdata <= bus.wdata; cap_wstrb <= bus.wstrb;
          w_hs_cyc <= cyc; w_hs_n <= w_hs_n + 1;
        end else w_cnt <= w_cnt + 1;
      end
      if ((aw_done || aw_fire) && (w_done || w_fire) && !bus.bvalid && !b_never) begin
        wr_a = aw_fire ? bus.awaddr : cap_awaddr;
        wr_d = w_fire ? bus.wdata : cap_wdata;
        bus.bvalid <= 1;
        bus.bresp  <= b_err ? 2'b10 : 2'b00;
        if (!b_err) resp_mem[wr_a >> 2] = wr_d[15:0];
        aw_done <= 0; w_done <= 0;
      end
      if (bus.bvalid && bus.bready) bus.bvalid <= 0;
      if (bus.arvalid && bus.arready) begin
        rd_key = bus.araddr >> 2;
        rd_val = resp_mem.exists(rd_key) ? resp_mem[rd_key] : 16'h0;
        rnd    = $urandom;
        cap_araddr <= bus.araddr; ar_hs_n <= ar_hs_n + 1;
        bus.rvalid <= 1;
        bus.rdata  <= {rnd[15:0], rd_val};
        bus.rresp  <= r_err ? 2'b10 : 2'b00;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 0;
    end
  end

  // ---------------- reference model and checking ----------------
  logic [15:0] model [logic [31:0]];
  int          model_err = 0;
  int          pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  int          acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    check({tag, "/rsp_arrived"}, rsp_valid, 1);
  endtask

  task automatic consume_rsp(input string tag);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check({tag, "/rsp_dropped"}, rsp_valid, 0);
    check({tag, "/ready_again"}, cmd_ready, 1);
    check({tag, "/idle"}, busy, 0);
  endtask

  task automatic do_op(input string tag, input bit wr, input logic [31:0] idx,
                       input logic [15:0] wd, input bit berr, input bit rerr);
    int n, aw0, w0, ar0;
    bit range_err, exp_err;
    logic [15:0] exp_rd;
    b_err = berr; r_err = rerr;
    aw0 = aw_hs_n; w0 = w_hs_n; ar0 = ar_hs_n;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_index = idx; cmd_wdata = wd;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "/cmd_ready"}, cmd_ready, 1);
    @(negedge clk);
    acc = cyc - 1;
    cmd_valid = 0;
    range_err = (idx >= NUM);
    check({tag, "/busy"}, busy, 1);
    if (range_err)  check({tag, "/rsp_next_cycle"}, rsp_valid, 1);
    else if (wr)    check({tag, "/aw_w_valid"}, {bus.awvalid, bus.wvalid}, 2'b11);
    else            check({tag, "/ar_valid"}, bus.arvalid, 1);
    wait_rsp(tag, 200);
    exp_err = range_err || (wr ? berr : rerr);
    exp_rd  = (!wr && !exp_err) ? (model.exists(idx) ? model[idx] : 16'h0) : 16'h0;
    check({tag, "/rsp_err"}, rsp_err, exp_err);
    check({tag, "/rsp_rdata"}, rsp_rdata, exp_rd);
    if (exp_err && model_err < 65535) model_err++;
    check({tag, "/err_count"}, err_count, model_err);
    if (range_err) begin
      check({tag, "/no_bus_traffic"}, (aw_hs_n - aw0) + (w_hs_n - w0) + (ar_hs_n - ar0), 0);
    end else if (wr) begin
      check({tag, "/awaddr"}, cap_awaddr, idx * 4);
      check({tag, "/wdata"}, cap_wdata, {16'h0, wd});
      check({tag, "/wstrb"}, cap_wstrb, 4'b0011);
    end else begin
      check({tag, "/araddr"}, cap_araddr, idx * 4);
    end
    check({tag, "/payload_stable"}, stab_err, 0);
    if (wr && !exp_err) model[idx] = wd;
    consume_rsp(tag);
  endtask

  int bad_ready, bad_stable;
  logic [15:0] snap_rd;
  logic        snap_err;

  initial begin
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_index = 0; cmd_wdata = 0; rsp_ready = 0;
    aw_lat = 0; w_lat = 0; b_err = 0; r_err = 0; b_never = 0;
    aw_hs_n = 0; w_hs_n = 0; ar_hs_n = 0; stab_err = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/cmd_ready", cmd_ready, 1);
    check("rst/busy", busy, 0);
    check("rst/rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    check("rst/err_count", err_count, 0);
    check("rst/timeout_flag", timeout_flag, 0);
    check("rst/valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    check("rst/addr_data", {bus.awaddr, bus.wdata}, 64'h0);
    rst = 0;

    // Basic write then read-back, out-of-range, and the last valid index
    do_op("t1_wr", 1, 5, 16'hBEEF, 0, 0);
    do_op("t2_rd", 0, 5, 16'h0, 0, 0);
    do_op("t3_range_rd", 0, NUM, 16'h0, 0, 0);
    do_op("t3_range_wr", 1, NUM, 16'h1111, 0, 0);
    do_op("bnd_wr", 1, NUM - 1, 16'h0F0F, 0, 0);
    do_op("bnd_rd", 0, NUM - 1, 16'h0, 0, 0);

    // AW taken at cycle 1, W at cycle 4; then a read answered with SLVERR
    aw_lat = 0; w_lat = 3;
    do_op("t4_wr", 1, 6, 16'hCAFE, 0, 0);
    check("t4/aw_cycle", aw_hs_cyc - acc, 1);
    check("t4/w_cycle", w_hs_cyc - acc, 4);
    w_lat = 0;
    do_op("t4_rd_slverr", 0, 6, 16'h0, 0, 1);

    // Randomized mix of reads, writes, range errors, bus errors and wait states
    for (int i = 0; i < 24; i++) begin
      int sel;
      logic [31:0] ridx;
      sel  = $urandom_range(0, 9);
      ridx = (sel == 0) ? NUM + $urandom_range(0, 1000) :
             (sel == 1) ? NUM - 1 : $urandom_range(0, 15);
      aw_lat = $urandom_range(0, 3);
      w_lat  = $urandom_range(0, 3);
      do_op("rand", 1'($urandom_range(0, 1)), ridx, 16'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    // Response back-pressure with a command waiting
    aw_lat = 0; w_lat = 0; b_err = 0; r_err = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 0; cmd_index = 5;
    @(negedge clk);
    cmd_write = 1; cmd_index = 7; cmd_wdata = 16'h1234;
    wait_rsp("t5", 50);
    check("t5/rdata", rsp_rdata, model.exists(32'd5) ? model[32'd5] : 16'h0);
    snap_rd = rsp_rdata; snap_err = rsp_err;
    bad_ready = 0; bad_stable = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0) bad_ready++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== snap_rd || rsp_err !== snap_err) bad_stable++;
    end
    check("t5/cmd_ready_held_low", bad_ready, 0);
    check("t5/rsp_stable", bad_stable, 0);
    consume_rsp("t5");
    @(negedge clk);
    check("t5/next_accepted", {busy, cmd_ready, bus.awvalid}, 3'b101);
    cmd_valid = 0;
    wait_rsp("t5_wr", 50);
    check("t5_wr/rsp_err", rsp_err, 0);
    check("t5_wr/awaddr", cap_awaddr, 32'd28);
    model[32'd7] = 16'h1234;
    consume_rsp("t5_wr");

`ifdef AXIL_LOADER_TIMEOUT_EN
    // Responder never answers B: watchdog recovers
    b_never = 1;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_index = 9; cmd_wdata = 16'h5555;
    @(negedge clk);
    cmd_valid = 0;
    wait_rsp("t6_to", 100);
    check("t6_to/rsp_err", rsp_err, 1);
    check("t6_to/rsp_rdata", rsp_rdata, 0);
    check("t6_to/timeout_flag", timeout_flag, 1);
    check("t6_to/valids_dropped", {bus.awvalid, bus.wvalid, bus.bready}, 0);
    if (model_err < 65535) model_err++;
    check("t6_to/err_count", err_count, model_err);
    consume_rsp("t6_to");
    b_never = 0;
`endif

    // Reset in the middle of a write
    aw_lat = 5;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_index = 3; cmd_wdata = 16'h7777;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    check("t6_rst/aw_pending", bus.awvalid, 1);
    #2 rst = 1;
    #1;
    check("t6_rst/valids_zero", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    check("t6_rst/outputs", {rsp_valid, busy, cmd_ready}, 3'b001);
    check("t6_rst/flags", {err_count, timeout_flag}, 0);
    @(negedge clk);
    rst = 0; aw_lat = 0; model_err = 0;
    repeat (5) @(negedge clk);
    check("t6_rst/no_response", rsp_valid, 0);
    do_op("post_rst_rd", 0, 5, 16'h0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
